// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches floor calls, issues one target at a time, runs the door dwell.
// Define CALL_SCHEDULER_SCAN_DIR_EN for direction-aware scan selection; otherwise the lowest call wins.
module call_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       stop,
  input  logic [1:0] cur_floor,
  output logic [1:0] req_floor,
  output logic       req_valid,
  output logic [3:0] pending,
  output logic       arrived,
  output logic       door_open,
  output logic [3:0] served_count
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_pending, w_pending_nxt;
  logic [1:0] r_req_floor, w_req_floor_nxt;
  logic       r_req_valid, w_req_valid_nxt;
  logic       r_arrived, w_arrived_nxt;
  logic       r_door_open, w_door_open_nxt;
  logic [3:0] r_served, w_served_nxt;
  logic [7:0] r_dwell, w_dwell_nxt;
  logic       w_arrive;
  logic [3:0] w_set, w_clr;
  logic [1:0] w_target;

`ifdef CALL_SCHEDULER_SCAN_DIR_EN
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  logic r_dir, w_dir_nxt, w_sel_dir, w_found;

  // Loop order picks the nearest candidate: later matches overwrite earlier ones.
  always_comb begin
    w_target  = 2'd0;
    w_sel_dir = r_dir;
    w_found   = 1'b0;
    if (r_dir == DIR_UP) begin
      for (int i = 3; i >= 0; i--)
        if (r_pending[i] && i >= int'(cur_floor)) begin
          w_target = 2'(i);
          w_found  = 1'b1;
        end
      if (!w_found) begin
        w_sel_dir = DIR_DOWN;
        for (int i = 0; i < 4; i++)
          if (r_pending[i] && i < int'(cur_floor)) w_target = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (r_pending[i] && i <= int'(cur_floor)) begin
          w_target = 2'(i);
          w_found  = 1'b1;
        end
      if (!w_found) begin
        w_sel_dir = DIR_UP;
        for (int i = 3; i >= 0; i--)
          if (r_pending[i] && i > int'(cur_floor)) w_target = 2'(i);
      end
    end
  end
`else
  always_comb begin
    w_target = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (r_pending[i]) w_target = 2'(i);
  end
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_req_floor_nxt = r_req_floor;
    w_req_valid_nxt = r_req_valid;
    w_door_open_nxt = r_door_open;
    w_served_nxt    = r_served;
    w_dwell_nxt     = r_dwell;
`ifdef CALL_SCHEDULER_SCAN_DIR_EN
    w_dir_nxt       = r_dir;
`endif
    w_arrive = (r_state == MOVE) && !stop && (cur_floor == r_req_floor);
    w_set    = btn;
    if (r_state == DOOR) w_set[cur_floor] = 1'b0;
    w_clr    = 4'd0;
    if (w_arrive) w_clr[r_req_floor] = 1'b1;
    // Clear beats a same-edge set of the served floor.
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
    w_arrived_nxt = w_arrive;
    if (!stop) begin
      case (r_state)
        IDLE: if (|r_pending) begin
          w_state_nxt     = MOVE;
          w_req_floor_nxt = w_target;
          w_req_valid_nxt = 1'b1;
`ifdef CALL_SCHEDULER_SCAN_DIR_EN
          w_dir_nxt       = w_sel_dir;
`endif
        end
        MOVE: if (w_arrive) begin
          w_state_nxt     = DOOR;
          w_req_valid_nxt = 1'b0;
          w_served_nxt    = r_served + 4'd1;
          w_door_open_nxt = 1'b1;
          w_dwell_nxt     = DWELL_LOAD;
        end
        DOOR: if (r_dwell == 8'd0) begin
          w_state_nxt     = IDLE;
          w_door_open_nxt = 1'b0;
        end else begin
          w_dwell_nxt     = r_dwell - 8'd1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= 4'd0;
      r_req_floor <= 2'd0;
      r_req_valid <= 1'b0;
      r_arrived   <= 1'b0;
      r_door_open <= 1'b0;
      r_served    <= 4'd0;
      r_dwell     <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_req_floor <= w_req_floor_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_arrived   <= w_arrived_nxt;
      r_door_open <= w_door_open_nxt;
      r_served    <= w_served_nxt;
      r_dwell     <= w_dwell_nxt;
    end
  end

`ifdef CALL_SCHEDULER_SCAN_DIR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dir <= DIR_UP;
    else     r_dir <= w_dir_nxt;
  end
`endif

  assign req_floor    = r_req_floor;
  assign req_valid    = r_req_valid;
  assign pending      = r_pending;
  assign arrived      = r_arrived;
  assign door_open    = r_door_open;
  assign served_count = r_served;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed scenarios plus random traffic against a behavioural model.
// Honours CALL_SCHEDULER_SCAN_DIR_EN the same way the design does.
module tb_call_scheduler;
  localparam int DWELL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       stop;
  logic [1:0] cur_floor;
  logic [1:0] req_floor;
  logic       req_valid;
  logic [3:0] pending;
  logic       arrived;
  logic       door_open;
  logic [3:0] served_count;

  call_scheduler #(.DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .btn(btn), .stop(stop), .cur_floor(cur_floor),
    .req_floor(req_floor), .req_valid(req_valid), .pending(pending),
    .arrived(arrived), .door_open(door_open), .served_count(served_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0 idle, 1 travelling, 2 door; door_left counts remaining open cycles
  int         m_phase, m_target, m_served, m_door_left;
  logic [3:0] m_pending;
  bit         m_valid, m_arrived, m_dir_up;
  int         r_cur;
  int         g_door, g_arr;
  int         served_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_target = 0; m_served = 0; m_door_left = 0;
    m_pending = 4'd0; m_valid = 0; m_arrived = 0; m_dir_up = 1;
  endtask

  task automatic select_target(input logic [3:0] p, input int cur, output int tgt);
    tgt = -1;
`ifdef CALL_SCHEDULER_SCAN_DIR_EN
    if (m_dir_up) begin
      for (int f = cur; f <= 3; f++) if (p[f] && tgt < 0) tgt = f;
      if (tgt < 0) begin
        m_dir_up = 0;
        for (int f = cur - 1; f >= 0; f--) if (p[f] && tgt < 0) tgt = f;
      end
    end else begin
      for (int f = cur; f >= 0; f--) if (p[f] && tgt < 0) tgt = f;
      if (tgt < 0) begin
        m_dir_up = 1;
        for (int f = cur + 1; f <= 3; f++) if (p[f] && tgt < 0) tgt = f;
      end
    end
`else
    for (int f = 0; f <= 3; f++) if (p[f] && tgt < 0) tgt = f;
`endif
  endtask

  task automatic model_step(input logic [3:0] b, input bit s, input int cur);
    logic [3:0] old_p, setm;
    bit arrive;
    int t;
    old_p = m_pending;
    arrive = (m_phase == 1) && !s && (cur == m_target);
    setm = b;
    if (m_phase == 2) setm[cur] = 1'b0;
    m_pending = old_p | setm;
    if (arrive) m_pending[m_target] = 1'b0;
    m_arrived = arrive;
    if (!s) begin
      case (m_phase)
        0: if (old_p != 0) begin
          select_target(old_p, cur, t);
          m_target = t; m_valid = 1; m_phase = 1;
        end
        1: if (arrive) begin
          m_phase = 2; m_valid = 0; m_served = (m_served + 1) % 16; m_door_left = DWELL;
        end
        default: begin
          m_door_left--;
          if (m_door_left == 0) m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("pending",   8'(pending),      8'(m_pending));
    check("req_valid", 8'(req_valid),    8'(m_valid));
    check("req_floor", 8'(req_floor),    8'(m_target));
    check("arrived",   8'(arrived),      8'(m_arrived));
    check("door_open", 8'(door_open),    8'(m_door_left > 0));
    check("served",    8'(served_count), 8'(m_served));
  endtask

  task automatic tick(input logic [3:0] b, input bit s, input logic [1:0] f);
    btn = b; stop = s; cur_floor = f;
    model_step(b, s, int'(f));
    @(negedge clk);
    compare_all();
    if (door_open) g_door++;
    if (arrived) begin
      g_arr++;
      served_q.push_back(int'(req_floor));
    end
  endtask

  // car moves one floor per cycle toward the live target; optionally press the floor it stands on
  task automatic step(input logic [3:0] b, input bit s, input bit press_here);
    int f;
    f = r_cur;
    if (m_phase == 1 && f != m_target) f = (f < m_target) ? f + 1 : f - 1;
    if (press_here && ((m_phase == 1 && f == m_target) || m_phase == 2)) b[f] = 1'b1;
    r_cur = f;
    tick(b, s, 2'(f));
  endtask

  task automatic run_until(input int phase, input bit need_empty, input bit press_here, input int max);
    bit done;
    done = 0;
    for (int n = 0; n < max && !done; n++) begin
      step(4'd0, 0, press_here);
      if (m_phase == phase && (!need_empty || m_pending == 4'd0)) done = 1;
    end
    check("run_done", 8'(done), 8'd1);
  endtask

  task automatic clear_stats();
    g_door = 0; g_arr = 0; served_q.delete();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_req_valid", 8'(req_valid),    8'd0);
    check("rst_req_floor", 8'(req_floor),    8'd0);
    check("rst_pending",   8'(pending),      8'd0);
    check("rst_arrived",   8'(arrived),      8'd0);
    check("rst_door",      8'(door_open),    8'd0);
    check("rst_served",    8'(served_count), 8'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 4'd0; stop = 1'b0; cur_floor = 2'd0; r_cur = 0;
    model_reset();
    clear_stats();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // single call to floor 3
    clear_stats();
    tick(4'b1000, 0, 2'd0);
    run_until(0, 1, 0, 50);
    check("s1_arrived_cnt", 8'(g_arr), 8'd1);
    check("s1_door_cycles", 8'(g_door), 8'(DWELL));
    check("s1_served", 8'(served_count), 8'd1);
    check("s1_pending", 8'(pending), 8'd0);
    check("s1_floor", 8'(served_q.size() > 0 ? served_q[0] : 9), 8'd3);

`ifdef CALL_SCHEDULER_SCAN_DIR_EN
    do_reset();
    clear_stats();
    r_cur = 1;
    tick(4'b1001, 0, 2'd1);
    run_until(0, 1, 0, 60);
    check("scan_cnt", 8'(served_q.size()), 8'd2);
    check("scan_first", 8'(served_q.size() > 0 ? served_q[0] : 9), 8'd3);
    check("scan_second", 8'(served_q.size() > 1 ? served_q[1] : 9), 8'd0);
    check("scan_served", 8'(served_count), 8'd2);
`else
    clear_stats();
    r_cur = 3;
    tick(4'b0110, 0, 2'd3);
    run_until(0, 1, 0, 60);
    check("multi_cnt", 8'(served_q.size()), 8'd2);
    check("multi_first", 8'(served_q.size() > 0 ? served_q[0] : 9), 8'd1);
    check("multi_second", 8'(served_q.size() > 1 ? served_q[1] : 9), 8'd2);
    check("multi_served", 8'(served_count), 8'd3);
`endif

    // stop during door dwell, floor 2 press latched meanwhile
    clear_stats();
    r_cur = 3;
    tick(4'b0001, 0, 2'd3);
    run_until(2, 0, 0, 50);
    step(4'd0, 0, 0);
    step(4'd0, 0, 0);
    for (int i = 0; i < 5; i++) step((i == 2) ? 4'b0100 : 4'd0, 1, 0);
    check("stop_hold_door", 8'(door_open), 8'd1);
    run_until(0, 0, 0, 50);
    check("stop_door_cycles", 8'(g_door), 8'(DWELL + 5));
    check("stop_latch", 8'(pending), 8'b0100);
    run_until(0, 1, 0, 60);

    // press the car's own floor on the arrival edge and through the dwell
    clear_stats();
    r_cur = 0;
    tick(4'b0100, 0, 2'd0);
    run_until(0, 1, 1, 60);
    check("coll_pending", 8'(pending), 8'd0);
    check("coll_arrivals", 8'(g_arr), 8'd1);

    // 16 services wrap the counter back to zero
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] b;
      b = 4'd0;
      b[$urandom_range(3)] = 1'b1;
      tick(b, 0, 2'(r_cur));
      run_until(0, 1, 0, 60);
    end
    check("wrap_served", 8'(served_count), 8'd0);

    // reset mid-travel with every floor pending
    r_cur = 0;
    tick(4'b1111, 0, 2'd0);
    r_cur = 3;
    tick(4'd0, 0, 2'd3);
    r_cur = (m_target == 0) ? 1 : 2;
    tick(4'd0, 0, 2'(r_cur));
    check("mid_move_valid", 8'(req_valid), 8'd1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'd0, 0, 2'(r_cur));
      check("post_rst_idle", 8'(req_valid), 8'd0);
    end
    tick(4'b0010, 0, 2'(r_cur));
    check("post_rst_one_edge", 8'(req_valid), 8'd0);
    tick(4'd0, 0, 2'(r_cur));
    check("post_rst_req", 8'(req_valid), 8'd1);
    run_until(0, 1, 0, 60);

    // random traffic with occasional stop
    for (int i = 0; i < 400; i++) begin
      logic [3:0] b;
      b = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0;
      step(b, $urandom_range(9) == 0, 0);
    end
    run_until(0, 1, 0, 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
